// File: rtl/target_loader.sv
// target_loader: producer side of the comparator's target interface.
// Captures a 256-bit mining target from the host, writes it into the target
// FIFO one word at a time (least-significant word first), then raises start
// toward the comparator and waits for a result. Also drives the stop/stop_ack
// handshake so the host can abort a job at any point after capture.
//
// Handshake rules (all interfaces of this block):
//   tgt_in is taken on a rising clk edge where tgt_valid & tgt_ready are both 1;
//   tgt_ready is a registered flag that is high only while the loader is idle.
//   A FIFO word is written on each rising clk edge where fifo_we is 1; fifo_we
//   is never raised while fifo_full or stop_req is high, so a full FIFO simply
//   stalls the sequence without skipping or repeating a word.
//   stop is held high until the comparator's stop_ack_comp is seen with stop
//   already high, so the comparator always observes at least one stop cycle.
module target_loader #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_W*WORDS-1:0]  tgt_in,
    input  logic                     tgt_valid,
    output logic                     tgt_ready,
    input  logic                     stop_req,
    output logic [WORD_W-1:0]        fifo_din,
    output logic                     fifo_we,
    input  logic                     fifo_full,
    output logic                     start,
    output logic                     stop,
    input  logic                     stop_ack_comp,
    input  logic                     result,
    output logic                     found,
    output logic                     busy,
    output logic [2:0]               state_loader_dbg
);

    localparam int TGT_W = WORD_W * WORDS;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PUSH = 3'd1,
        S_RUN  = 3'd2,
        S_STOP = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TGT_W-1:0]   tgt_q, tgt_d;
    logic               found_q, found_d;
    logic               start_q, start_d;
    logic               stop_q, stop_d;
    logic               tgt_ready_q, tgt_ready_d;
    logic               busy_q, busy_d;

    // FIFO write strobe and data are combinational so a full FIFO or an abort
    // request suppresses the write in the very same cycle.
    assign fifo_we  = (state_q == S_PUSH) && !fifo_full && !stop_req;
    assign fifo_din = tgt_q[cnt_q*WORD_W +: WORD_W];

    assign tgt_ready        = tgt_ready_q;
    assign start            = start_q;
    assign stop             = stop_q;
    assign found            = found_q;
    assign busy             = busy_q;
    assign state_loader_dbg = state_q;

    // Next-state logic; registered outputs are derived from the next state so
    // they line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        found_d = found_q;

        case (state_q)
            S_IDLE: begin
                // stop_req is deliberately ignored here: there is no job to abort.
                if (tgt_valid && tgt_ready_q) begin
                    tgt_d   = tgt_in;
                    found_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (stop_req) begin
                    // Partially written target is abandoned; host owns FIFO flush.
                    state_d = S_STOP;
                end else if (fifo_we) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // A result arriving together with an abort still counts as found.
                if (result) begin
                    found_d = 1'b1;
                end
                if (stop_req) begin
                    state_d = S_STOP;
                end else if (result) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Wait for result to fall so start is never re-armed on a stale hit.
                if (stop_req) begin
                    state_d = S_STOP;
                end else if (!result) begin
                    state_d = S_IDLE;
                end
            end
            S_STOP: begin
                // Require our own stop to be visible before trusting the ack,
                // since the comparator's ack idles high.
                if (stop_q && stop_ack_comp) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d     = (state_d == S_RUN);
        stop_d      = (state_d == S_STOP);
        tgt_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tgt_q       <= '0;
            found_q     <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            tgt_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            found_q     <= found_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            tgt_ready_q <= tgt_ready_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_target_loader.sv
// Bench for target_loader: directed scenarios followed by randomized jobs.
// FIFO words are predicted from the target value and checked by a monitor.
module tb_target_loader;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PUSH = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_STOP = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] tgt_in;
    logic         tgt_valid;
    logic         tgt_ready;
    logic         stop_req;
    logic [31:0]  fifo_din;
    logic         fifo_we;
    logic         fifo_full;
    logic         start;
    logic         stop;
    logic         stop_ack_comp;
    logic         result;
    logic         found;
    logic         busy;
    logic [2:0]   state_loader_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    target_loader #(.WORD_W(32), .WORDS(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .tgt_in           (tgt_in),
        .tgt_valid        (tgt_valid),
        .tgt_ready        (tgt_ready),
        .stop_req         (stop_req),
        .fifo_din         (fifo_din),
        .fifo_we          (fifo_we),
        .fifo_full        (fifo_full),
        .start            (start),
        .stop             (stop),
        .stop_ack_comp    (stop_ack_comp),
        .result           (result),
        .found            (found),
        .busy             (busy),
        .state_loader_dbg (state_loader_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the next predicted word.
    always @(negedge clk) begin
        if (!rst && fifo_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {32'd0, fifo_din}, 64'hdead_0000_0000_0000);
            end else begin
                check("fifo_word", {32'd0, fifo_din}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: target splits into 8 words, least-significant first.
    task automatic predict_words(input logic [255:0] t);
        logic [255:0] sh;
        for (int i = 0; i < 8; i++) begin
            sh = t >> (32 * i);
            exp_q.push_back(sh[31:0]);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tgt_ready"}, tgt_ready, 0);
        check({tag, "_fifo_we"}, fifo_we, 0);
        check({tag, "_fifo_din"}, fifo_din, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_stop"}, stop, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_state"}, state_loader_dbg, ST_IDLE);
    endtask

    // mode: 0 no stalls, 1 four-cycle stall at word 3, 2 random stalls.
    // abort_at: word count at which to abort (-1 none); abort_kind 0=stop_req, 1=rst.
    task automatic load_target(input logic [255:0] t, input int mode, input int abort_at,
                               input int abort_kind, output bit aborted);
        int  n;
        int  cyc;
        int  stall_left;
        bit  stall_done;
        bit  full;
        aborted    = 0;
        stall_left = 0;
        stall_done = 0;
        cyc = 0;
        while (!tgt_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("ready_before_load", tgt_ready, 1);
        tgt_in    = t;
        tgt_valid = 1'b1;
        predict_words(t);
        tick();
        tgt_valid = 1'b0;
        tgt_in    = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
        check("accept_state", state_loader_dbg, ST_PUSH);
        check("accept_busy", busy, 1);
        check("accept_ready", tgt_ready, 0);
        check("accept_found_clr", found, 0);
        n   = 0;
        cyc = 0;
        while (n < 8 && cyc < 200) begin
            if (n == abort_at) begin
                fifo_full = 1'b0;
                if (abort_kind == 0) begin
                    stop_req = 1'b1;
                    @(negedge clk);
                    check("stop_blocks_write", fifo_we, 0);
                    tick();
                    stop_req = 1'b0;
                    check("push_stop_state", state_loader_dbg, ST_STOP);
                    check("push_stop_high", stop, 1);
                    check("push_stop_start", start, 0);
                    tick();
                    check("push_stop_exit", state_loader_dbg, ST_IDLE);
                    check("push_stop_low", stop, 0);
                    check("push_stop_ready", tgt_ready, 1);
                    check("push_stop_found", found, 0);
                    check("abandoned_words", exp_q.size(), 8 - n);
                end else begin
                    rst = 1'b1;
                    tick();
                    check_reset_values("midrst");
                    rst = 1'b0;
                    tick();
                    check("midrst_ready", tgt_ready, 1);
                end
                exp_q.delete();
                aborted = 1;
                return;
            end
            case (mode)
                1: begin
                    if (n == 3 && !stall_done) begin
                        stall_left = 4;
                        stall_done = 1;
                    end
                    full = (stall_left > 0);
                    if (full) stall_left--;
                end
                2: full = ($urandom_range(0, 3) == 0);
                default: full = 1'b0;
            endcase
            fifo_full = full;
            @(negedge clk);
            check("fifo_we", fifo_we, !full);
            check("start_low_in_push", start, 0);
            if (!full) n++;
            tick();
            cyc++;
        end
        fifo_full = 1'b0;
        check("run_state", state_loader_dbg, ST_RUN);
        check("start_after_last", start, 1);
        @(negedge clk);
        check("no_write_after_8", fifo_we, 0);
        tick();
    endtask

    // In RUN: wait delay cycles, then hold result high for pulse cycles.
    task automatic run_result(input int delay, input int pulse);
        for (int d = 0; d < delay; d++) begin
            check("run_start_held", start, 1);
            check("run_found_low", found, 0);
            check("run_ready_low", tgt_ready, 0);
            tgt_valid = (d == 0);
            tick();
        end
        tgt_valid = 1'b0;
        check("run_state_before_result", state_loader_dbg, ST_RUN);
        result = 1'b1;
        tick();
        check("done_found", found, 1);
        check("done_start", start, 0);
        check("done_state", state_loader_dbg, ST_DONE);
        for (int p = 1; p < pulse; p++) begin
            tick();
            check("done_hold_state", state_loader_dbg, ST_DONE);
            check("done_hold_start", start, 0);
        end
        result = 1'b0;
        tick();
        check("done_exit_state", state_loader_dbg, ST_IDLE);
        check("done_exit_ready", tgt_ready, 1);
        check("done_exit_busy", busy, 0);
        check("done_exit_found", found, 1);
    endtask

    // In RUN: abort; ack held low for ack_delay cycles after stop rises.
    task automatic stop_run(input int ack_delay, input bit with_result);
        stop_ack_comp = (ack_delay == 0);
        stop_req      = 1'b1;
        result        = with_result;
        tick();
        stop_req = 1'b0;
        result   = 1'b0;
        check("run_stop_state", state_loader_dbg, ST_STOP);
        check("run_stop_high", stop, 1);
        check("run_stop_start", start, 0);
        check("run_stop_found", found, with_result);
        for (int a = 0; a < ack_delay; a++) begin
            tick();
            check("stop_wait_high", stop, 1);
            check("stop_wait_start", start, 0);
            check("stop_wait_state", state_loader_dbg, ST_STOP);
        end
        stop_ack_comp = 1'b1;
        tick();
        check("stop_exit_state", state_loader_dbg, ST_IDLE);
        check("stop_exit_low", stop, 0);
        check("stop_exit_ready", tgt_ready, 1);
        check("stop_exit_found", found, with_result);
    endtask

    initial begin
        logic [255:0] t;
        bit           ab;
        int           r;
        rst           = 1'b1;
        tgt_in        = '0;
        tgt_valid     = 1'b0;
        stop_req      = 1'b0;
        fifo_full     = 1'b0;
        stop_ack_comp = 1'b1;
        result        = 1'b0;
        tick();
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();
        check("ready_after_reset", tgt_ready, 1);

        // stop_req while idle does nothing
        stop_req = 1'b1;
        tick();
        tick();
        check("idle_stop_ignored", stop, 0);
        check("idle_stop_state", state_loader_dbg, ST_IDLE);
        check("idle_stop_ready", tgt_ready, 1);
        stop_req = 1'b0;

        t = 256'h00000007_66666666_55555555_44444444_33333333_aaaaaaaa_11111111_22222222;
        load_target(t, 0, -1, 0, ab);
        run_result(2, 2);
        load_target(t, 1, -1, 0, ab);
        run_result(0, 1);
        load_target(256'hfedcba98_76543210_0f1e2d3c_4b5a6978_deadbeef_cafef00d_01234567_89abcdef,
                    0, 4, 0, ab);
        load_target(t, 0, -1, 0, ab);
        stop_run(5, 0);
        load_target(~t, 2, -1, 0, ab);
        stop_run(0, 1);
        load_target(t, 0, 3, 1, ab);

        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
            load_target(t, 2, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1, 0, ab);
            if (!ab) begin
                r = $urandom_range(0, 2);
                if (r < 2) run_result($urandom_range(0, 4), $urandom_range(1, 3));
                else       stop_run($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
